// File: rtl/usb_pkg.sv
// Shared definitions for the USB receive path: transfer-size encoding and buffer depth.
package usb_pkg;

    localparam logic [1:0] SIZE_BYTE     = 2'b01;
    localparam logic [1:0] SIZE_HALF     = 2'b10;
    localparam logic [1:0] SIZE_WORD     = 2'b11;
    localparam int         DEPTH_DEFAULT = 64;

    // 2'b00 behaves like a byte access, matching hsize usage on the AHB side
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        case (size)
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/usb_rx_data_buffer_if.sv
// Receiver/AHB-side signal bundle of the receive data buffer.
interface usb_rx_data_buffer_if #(
    parameter int OCC_W = 7
);
    logic             flush;
    logic             w_enable;
    logic [7:0]       wr_data;
    logic             rd_enable;
    logic [1:0]       rd_size;
    logic [31:0]      rd_data;
    logic             rd_valid;
    logic [OCC_W-1:0] buffer_occupancy;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, w_enable, wr_data, rd_enable, rd_size,
        input  rd_data, rd_valid, buffer_occupancy, empty, full, overflow, underflow
    );

    modport slave (
        input  flush, w_enable, wr_data, rd_enable, rd_size,
        output rd_data, rd_valid, buffer_occupancy, empty, full, overflow, underflow
    );
endinterface

// File: rtl/usb_fifo_mem.sv
// Byte storage array: one synchronous write port, four combinational read ports
// at consecutive (wrapping) addresses for word-wide pops.
module usb_fifo_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [7:0]      i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [3:0][7:0] o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // AW-bit address arithmetic wraps modulo DEPTH on its own
    for (genvar k = 0; k < 4; k++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr     = i_raddr + AW'(k);
        assign o_rdata[k] = r_mem[w_addr];
    end

endmodule

// File: rtl/usb_rx_data_buffer.sv
// Receive payload FIFO between usb_receiver and the AHB slave: byte pushes,
// 1/2/4-byte pops, occupancy reporting and flush at packet start.
module usb_rx_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int OCC_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    usb_rx_data_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_empty;
    logic             r_full;
    logic [31:0]      r_rd_data;
    logic             r_rd_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic [2:0]       w_n;
    logic [OCC_W-1:0] w_n_ext;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic             w_mem_we;
    logic [OCC_W-1:0] w_occ_next;
    logic [3:0][7:0]  w_mem_rd;
    logic [31:0]      w_rd_word;

    assign w_n      = size_to_bytes(bus.rd_size);
    assign w_n_ext  = OCC_W'(w_n);
    assign w_wr_acc = bus.w_enable  && (r_occ < OCC_W'(DEPTH));
    assign w_rd_acc = bus.rd_enable && (r_occ >= w_n_ext);
    assign w_mem_we = w_wr_acc && !bus.flush && !rst;

    always_comb begin
        w_occ_next = r_occ;
        if (w_wr_acc) begin
            w_occ_next = w_occ_next + OCC_W'(1);
        end
        if (w_rd_acc) begin
            w_occ_next = w_occ_next - w_n_ext;
        end
    end

    // Bytes beyond the requested size are forced to zero
    always_comb begin
        w_rd_word = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_n) begin
                w_rd_word[8*k +: 8] = w_mem_rd[k];
            end
        end
    end

    usb_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_rd_data   <= 32'h0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.flush) begin
            // rd_data deliberately survives a flush
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + AW'(w_n);
                r_rd_data <= w_rd_word;
            end
            r_occ       <= w_occ_next;
            r_empty     <= (w_occ_next == '0);
            r_full      <= (w_occ_next == OCC_W'(DEPTH));
            r_rd_valid  <= w_rd_acc;
            r_overflow  <= bus.w_enable  && !w_wr_acc;
            r_underflow <= bus.rd_enable && !w_rd_acc;
        end
    end

    assign bus.rd_data          = r_rd_data;
    assign bus.rd_valid         = r_rd_valid;
    assign bus.buffer_occupancy = r_occ;
    assign bus.empty            = r_empty;
    assign bus.full             = r_full;
    assign bus.overflow         = r_overflow;
    assign bus.underflow        = r_underflow;

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// Scoreboard bench for usb_rx_data_buffer: byte-queue reference model, directed
// scenarios followed by randomized traffic.
module tb_usb_rx_data_buffer;

    localparam int DEPTH = 64;
    localparam int OCC_W = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;

    usb_rx_data_buffer_if #(.OCC_W(OCC_W)) bus ();

    usb_rx_data_buffer #(.DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  model_q [$];
    logic [31:0] exp_q   [$];
    logic [31:0] e_last  = 32'h0;
    bit          e_ovf   = 0;
    bit          e_unf   = 0;
    bit          e_valid = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rd_valid must match the oldest outstanding expected word
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_valid_unexpected: got data %h with no read pending at %0t", bus.rd_data, $time);
            end else begin
                chk("rd_data_scoreboard", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus, applied after a falling edge; model evaluated on pre-edge state
    task automatic step(input bit we, input logic [7:0] d, input bit re, input logic [1:0] sz,
                        input bit fl, input bit rs);
        int          n;
        int          pre;
        bit          wacc;
        bit          racc;
        logic [31:0] word;
        rst           = rs;
        bus.flush     = fl;
        bus.w_enable  = we;
        bus.wr_data   = d;
        bus.rd_enable = re;
        bus.rd_size   = sz;
        n = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
        if (rs) begin
            model_q.delete();
            e_ovf = 0; e_unf = 0; e_valid = 0; e_last = 32'h0;
        end else if (fl) begin
            model_q.delete();
            e_ovf = 0; e_unf = 0; e_valid = 0;
        end else begin
            pre  = model_q.size();
            wacc = we && (pre < DEPTH);
            racc = re && (pre >= n);
            if (racc) begin
                word = 32'h0;
                for (int k = 0; k < n; k++) word[8*k +: 8] = model_q.pop_front();
                exp_q.push_back(word);
                e_last = word;
            end
            if (wacc) model_q.push_back(d);
            e_ovf   = we && !wacc;
            e_unf   = re && !racc;
            e_valid = racc;
        end
        @(posedge clk);
        #1;
        chk("occupancy", 32'(bus.buffer_occupancy), 32'(model_q.size()));
        chk("empty",     32'(bus.empty),     32'(model_q.size() == 0));
        chk("full",      32'(bus.full),      32'(model_q.size() == DEPTH));
        chk("overflow",  32'(bus.overflow),  32'(e_ovf));
        chk("underflow", 32'(bus.underflow), 32'(e_unf));
        chk("rd_valid",  32'(bus.rd_valid),  32'(e_valid));
        chk("rd_data_hold", bus.rd_data, e_last);
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] d);
        step(1, d, 0, 2'b00, 0, 0);
    endtask

    task automatic rd(input logic [1:0] sz);
        step(0, 8'h00, 1, sz, 0, 0);
    endtask

    task automatic reset_dut();
        step(0, 8'h00, 0, 2'b00, 0, 1);
    endtask

    initial begin
        rst = 1'b0;
        bus.flush = 0; bus.w_enable = 0; bus.wr_data = 0; bus.rd_enable = 0; bus.rd_size = 0;
        @(negedge clk);

        // Fill and drain
        reset_dut();
        chk("reset_empty", 32'(bus.empty), 32'd1);
        chk("reset_rd_data", bus.rd_data, 32'h0);
        wr(8'hAA); wr(8'hAB); wr(8'hEF); wr(8'hFF);
        chk("fill_occ", 32'(bus.buffer_occupancy), 32'd4);
        rd(2'b11);
        chk("drain_word", bus.rd_data, 32'hFFEFABAA);
        chk("drain_empty", 32'(bus.empty), 32'd1);
        step(0, 8'h00, 0, 2'b00, 0, 0);

        // Mixed widths
        for (int i = 0; i < 7; i++) wr(8'h11 + 8'(i));
        rd(2'b01); chk("mixed_byte", bus.rd_data, 32'h00000011);
        rd(2'b10); chk("mixed_half", bus.rd_data, 32'h00001312);
        rd(2'b11); chk("mixed_word", bus.rd_data, 32'h17161514);
        chk("mixed_occ", 32'(bus.buffer_occupancy), 32'd0);

        // Full and overflow
        reset_dut();
        for (int i = 0; i < 64; i++) wr(8'(i));
        chk("full_flag", 32'(bus.full), 32'd1);
        wr(8'hEE);
        chk("overflow_pulse", 32'(bus.overflow), 32'd1);
        chk("overflow_occ", 32'(bus.buffer_occupancy), 32'd64);
        rd(2'b00);
        chk("full_first_byte", bus.rd_data, 32'h00000000);

        // Underflow
        reset_dut();
        wr(8'h21); wr(8'h22);
        rd(2'b11);
        chk("underflow_pulse", 32'(bus.underflow), 32'd1);
        chk("underflow_occ", 32'(bus.buffer_occupancy), 32'd2);
        rd(2'b10);
        chk("underflow_recover", bus.rd_data, 32'h00002221);

        // Wrap with simultaneous read and write
        reset_dut();
        for (int i = 0; i < 62; i++) wr(8'h80 ^ 8'(i));
        for (int i = 0; i < 31; i++) rd(2'b10);
        wr(8'hC0); wr(8'hC1); wr(8'hC2); wr(8'hC3);
        step(1, 8'hC4, 1, 2'b11, 0, 0);
        chk("wrap_word", bus.rd_data, 32'hC3C2C1C0);
        chk("wrap_occ", 32'(bus.buffer_occupancy), 32'd1);

        // Flush priority, then reset mid-stream
        reset_dut();
        for (int i = 0; i < 10; i++) wr(8'h50 + 8'(i));
        rd(2'b11);
        step(1, 8'h99, 1, 2'b11, 1, 0);
        chk("flush_occ", 32'(bus.buffer_occupancy), 32'd0);
        chk("flush_keeps_data", bus.rd_data, 32'h53525150);
        wr(8'h61); wr(8'h62);
        step(1, 8'h63, 1, 2'b01, 1, 1);
        chk("rst_rd_data", bus.rd_data, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
                 2'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 255) == 0);
        end

        step(0, 8'h00, 0, 2'b00, 0, 0);
        step(0, 8'h00, 0, 2'b00, 0, 0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reads_outstanding: got %0d pending reads expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
